cache_switch_ctrl: RTL

//  Responder for the custom cache-switch instruction (opcode 7'b1111111): consumes the decoder's switch_cache_w strobe plus the target bank id.

---
 rtl/cache_switch_ctrl_pkg.sv | 29 ++
 rtl/cache_switch_ctrl_timer.sv | 32 +++
 rtl/cache_switch_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_switch_ctrl_pkg.sv
// Shared definitions for the cache-switch responder: opcode, FSM state encodings,
// default bank geometry and a width helper for the flush timeout counter.
package cache_switch_ctrl_pkg;

   localparam logic [6:0] OPC_SWITCH_CACHE = 7'b1111111;

   localparam int DEF_NUM_CACHES = 4;
   localparam int DEF_ID_W       = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DRAIN  = 3'd1;
   localparam logic [2:0] ST_FLUSH  = 3'd2;
   localparam logic [2:0] ST_SWITCH = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_DRAIN  = ST_DRAIN,
      S_FLUSH  = ST_FLUSH,
      S_SWITCH = ST_SWITCH,
      S_DONE   = ST_DONE
   } switch_state_t;

   // A zero timeout still needs a one-bit counter so the expired flag is well formed.
   function automatic int timer_width(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/cache_switch_ctrl_timer.sv
// Flush watchdog: counts cycles while enabled, saturates at MAX_COUNT and
// raises expired once that many cycles have elapsed since the last clear.
module switch_timer
   import cache_switch_ctrl_pkg::*;
#(
   parameter int MAX_COUNT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            W     = timer_width(MAX_COUNT);
   localparam logic [W-1:0]  LIMIT = W'(MAX_COUNT);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/cache_switch_ctrl.sv
// Cache-switch responder: stalls the pipeline, drains the I/D caches, optionally
// flushes the outgoing D-bank, then retargets active_cache_id and retires the request.
module cache_switch_ctrl
   import cache_switch_ctrl_pkg::*;
#(
   parameter int NUM_CACHES      = DEF_NUM_CACHES,
   parameter int ID_W            = DEF_ID_W,
   parameter int RESET_ID        = 0,
   parameter bit FLUSH_ON_SWITCH = 1'b1,
   parameter int FLUSH_TIMEOUT   = 255,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             switch_cache_w,
   input  logic [ID_W-1:0]  switch_id,
   input  logic             i_cache_busy,
   input  logic             d_cache_busy,
   input  logic             flush_done,
   output logic             switch_busywait,
   output logic             flush_req,
   output logic [ID_W-1:0]  flush_id,
   output logic [ID_W-1:0]  active_cache_id,
   output logic             switch_done,
   output logic             switch_err,
   output logic [CNT_W-1:0] switch_count
);

   localparam logic [ID_W-1:0] RST_ID   = ID_W'(RESET_ID);
   localparam logic [ID_W:0]   ID_LIMIT = (ID_W + 1)'(NUM_CACHES);

   switch_state_t   state;
   logic [ID_W-1:0] target;
   logic            invalid_id;
   logic            tmr_expired;

   assign invalid_id = ({1'b0, switch_id} >= ID_LIMIT);

   switch_timer #(
      .MAX_COUNT (FLUSH_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != S_FLUSH),
      .enable  (state == S_FLUSH),
      .expired (tmr_expired)
   );

   // Done/err are pulses raised on the transition into DONE; in FLUSH a completed
   // flush takes priority over a watchdog expiry in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         target          <= RST_ID;
         active_cache_id <= RST_ID;
         flush_req       <= 1'b0;
         flush_id        <= RST_ID;
         switch_done     <= 1'b0;
         switch_err      <= 1'b0;
         switch_count    <= '0;
      end else begin
         switch_done <= 1'b0;
         switch_err  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (switch_cache_w) begin
                  target <= switch_id;
                  if (invalid_id) begin
                     state       <= S_DONE;
                     switch_done <= 1'b1;
                     switch_err  <= 1'b1;
                  end else if (switch_id == active_cache_id) begin
                     state       <= S_DONE;
                     switch_done <= 1'b1;
                  end else begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (!i_cache_busy && !d_cache_busy) begin
                  if (FLUSH_ON_SWITCH) begin
                     state     <= S_FLUSH;
                     flush_req <= 1'b1;
                     flush_id  <= active_cache_id;
                  end else begin
                     state <= S_SWITCH;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_done) begin
                  flush_req <= 1'b0;
                  state     <= S_SWITCH;
               end else if (tmr_expired) begin
                  flush_req   <= 1'b0;
                  state       <= S_DONE;
                  switch_done <= 1'b1;
                  switch_err  <= 1'b1;
               end
            end
            S_SWITCH: begin
               active_cache_id <= target;
               if (switch_count != '1) begin
                  switch_count <= switch_count + 1'b1;
               end
               state       <= S_DONE;
               switch_done <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Released in DONE so the stalled switch instruction can retire.
   assign switch_busywait = ((state == S_IDLE) && switch_cache_w) ||
                            (state == S_DRAIN) ||
                            (state == S_FLUSH) ||
                            (state == S_SWITCH);

endmodule
